// File: rtl/button_event_decoder_if.sv
// Button event bus: debounced level in, single-cycle events and press count out.
interface button_event_decoder_if;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    modport master (
        output btn_level,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );

    modport slave (
        input  btn_level,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );
endinterface

// File: rtl/button_event_decoder.sv
// Converts a debounced button level into press/release/long/repeat pulses and a press count.
// A button already held at reset is ignored until it has been released once.
module button_event_decoder #(
    parameter int unsigned                COUNT_WIDTH   = 24,
    parameter logic [COUNT_WIDTH-1:0]     LONG_CYCLES   = COUNT_WIDTH'(10_000_000),
    parameter logic [COUNT_WIDTH-1:0]     REPEAT_CYCLES = COUNT_WIDTH'(2_500_000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_event_decoder_if.slave bus
);
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd0;
    localparam logic [1:0] ST_IDLE         = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_LONG         = 2'd3;

    // Terminal values: the clearing edge counts as the first cycle of the interval.
    localparam logic [COUNT_WIDTH-1:0] LONG_LAST   = LONG_CYCLES - COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] REPEAT_LAST = REPEAT_CYCLES - COUNT_WIDTH'(1);

    logic [1:0]             state, state_nxt;
    logic [COUNT_WIDTH-1:0] count, count_nxt;
    logic                   press_q, press_nxt;
    logic                   release_q, release_nxt;
    logic                   long_q, long_nxt;
    logic                   repeat_q, repeat_nxt;
    logic                   held_q, held_nxt;
    logic [7:0]             press_count_q, press_count_nxt;

    // Next-state and next-output logic; release always wins over long/repeat.
    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        press_nxt       = 1'b0;
        release_nxt     = 1'b0;
        long_nxt        = 1'b0;
        repeat_nxt      = 1'b0;
        press_count_nxt = press_count_q;

        case (state)
            ST_WAIT_RELEASE: begin
                if (!bus.btn_level) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.btn_level) begin
                    state_nxt       = ST_PRESSED;
                    press_nxt       = 1'b1;
                    press_count_nxt = press_count_q + 8'd1;
                    count_nxt       = '0;
                end
            end
            ST_PRESSED: begin
                if (!bus.btn_level) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                    count_nxt   = '0;
                end else if (count == LONG_LAST) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + COUNT_WIDTH'(1);
                end
            end
            ST_LONG: begin
                if (!bus.btn_level) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                    count_nxt   = '0;
                end else if (count == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    count_nxt  = '0;
                end else begin
                    count_nxt = count + COUNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_WAIT_RELEASE;
                count_nxt = '0;
            end
        endcase

        held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_WAIT_RELEASE;
            count         <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            press_q       <= press_nxt;
            release_q     <= release_nxt;
            long_q        <= long_nxt;
            repeat_q      <= repeat_nxt;
            held_q        <= held_nxt;
            press_count_q <= press_count_nxt;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
    assign bus.press_count   = press_count_q;
endmodule
